// File: rtl/cache_pkg.sv
// Shared definitions for the instruction cache: FSM state encoding,
// default geometry and the instruction value presented while stalled.
package cache_pkg;

  typedef enum logic [1:0] {
    IC_IDLE = 2'd0,
    IC_FILL = 2'd1,
    IC_WAIT = 2'd2
  } ic_state_t;

  localparam int unsigned IC_INDEX_BITS  = 6;
  localparam int unsigned IC_OFFSET_BITS = 3;

  localparam logic [15:0] IC_STALL_INSTR = 16'h0000;

endpackage

// File: rtl/icache_array.sv
// Tag, valid and data storage for the direct-mapped instruction cache.
// Asynchronous read port; one word write port, one tag/valid write port
// (sharing the write index) and a flush-all that clears every valid bit.
// Only the valid bits are reset.
module icache_array
  import cache_pkg::*;
#(
  parameter int unsigned INDEX_BITS  = IC_INDEX_BITS,
  parameter int unsigned OFFSET_BITS = IC_OFFSET_BITS
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [INDEX_BITS-1:0]             rd_index,
  input  logic [OFFSET_BITS-1:0]            rd_word,
  output logic [15-INDEX_BITS-OFFSET_BITS-1:0] rd_tag,
  output logic                              rd_valid,
  output logic [15:0]                       rd_data,
  input  logic                              wr_en,
  input  logic [INDEX_BITS-1:0]             wr_index,
  input  logic [OFFSET_BITS-1:0]            wr_word,
  input  logic [15:0]                       wr_data,
  input  logic                              tag_we,
  input  logic [15-INDEX_BITS-OFFSET_BITS-1:0] tag_data,
  input  logic                              tag_valid,
  input  logic                              flush_all
);

  localparam int unsigned TAG_BITS = 15 - INDEX_BITS - OFFSET_BITS;
  localparam int unsigned SETS     = 1 << INDEX_BITS;
  localparam int unsigned WORDS    = 1 << OFFSET_BITS;

  logic [15:0]         data_q  [SETS][WORDS];
  logic [TAG_BITS-1:0] tag_q   [SETS];
  logic [SETS-1:0]     valid_q;

  assign rd_data  = data_q[rd_index][rd_word];
  assign rd_tag   = tag_q[rd_index];
  assign rd_valid = valid_q[rd_index];

  // Data and tag storage: plain flops, no reset.
  always_ff @(posedge clk) begin
    if (wr_en) data_q[wr_index][wr_word] <= wr_data;
    if (tag_we) tag_q[wr_index] <= tag_data;
  end

  // Valid bits: flush-all takes priority over a simultaneous line update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (flush_all) begin
      valid_q <= '0;
    end else if (tag_we) begin
      valid_q[wr_index] <= tag_valid;
    end
  end

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller between fetch and a
// multi-cycle main memory. Hits return combinationally; misses stall,
// refill the whole block word-by-word and then replay the lookup.
// Optional hit/miss statistics outputs are enabled with ICACHE_STATS_EN.
module icache_ctrl
  import cache_pkg::*;
#(
  parameter int unsigned INDEX_BITS  = IC_INDEX_BITS,
  parameter int unsigned OFFSET_BITS = IC_OFFSET_BITS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic [15:0] cpu_addr,
  input  logic        flush,
  output logic [15:0] cpu_instr,
  output logic        cpu_stall,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic [15:0] mem_rdata,
  input  logic        mem_rvalid
`ifdef ICACHE_STATS_EN
  ,
  output logic [15:0] hit_cnt,
  output logic [15:0] miss_cnt
`endif
);

  localparam int unsigned TAG_BITS = 15 - INDEX_BITS - OFFSET_BITS;
  localparam int unsigned TAG_LSB  = OFFSET_BITS + INDEX_BITS + 1;

  ic_state_t              state;
  logic [TAG_BITS-1:0]    req_tag;
  logic [INDEX_BITS-1:0]  req_index;
  logic [OFFSET_BITS-1:0] req_word;
  logic [TAG_BITS-1:0]    fill_tag;
  logic [INDEX_BITS-1:0]  fill_index;
  logic [OFFSET_BITS-1:0] issue_cnt;
  logic [OFFSET_BITS-1:0] issue_next;
  logic [OFFSET_BITS-1:0] ret_cnt;
  logic                   fill_flushed;
  logic [TAG_BITS-1:0]    rd_tag;
  logic                   rd_valid;
  logic [15:0]            rd_data;
  logic                   lookup_hit;
  logic                   hit;
  logic                   miss;
  logic                   ret_active;
  logic                   last_ret;
  logic                   last_issue;
  logic                   unused_addr_lsb;

  assign req_tag         = cpu_addr[15:TAG_LSB];
  assign req_index       = cpu_addr[OFFSET_BITS+INDEX_BITS:OFFSET_BITS+1];
  assign req_word        = cpu_addr[OFFSET_BITS:1];
  assign unused_addr_lsb = cpu_addr[0];

  icache_array #(
    .INDEX_BITS  (INDEX_BITS),
    .OFFSET_BITS (OFFSET_BITS)
  ) u_array (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_index  (req_index),
    .rd_word   (req_word),
    .rd_tag    (rd_tag),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .wr_en     (ret_active),
    .wr_index  (fill_index),
    .wr_word   (ret_cnt),
    .wr_data   (mem_rdata),
    .tag_we    (last_ret),
    .tag_data  (fill_tag),
    .tag_valid (~(fill_flushed | flush)),
    .flush_all (flush)
  );

  // Lookup, stall and return-path decode.
  always_comb begin
    lookup_hit = cpu_req & rd_valid & (rd_tag == req_tag);
    hit        = (state == IC_IDLE) & lookup_hit;
    miss       = (state == IC_IDLE) & cpu_req & ~lookup_hit;
    cpu_stall  = (state != IC_IDLE) | miss;
    cpu_instr  = hit ? rd_data : IC_STALL_INSTR;
    ret_active = (state != IC_IDLE) & mem_rvalid;
    last_ret   = ret_active & (ret_cnt == '1);
    last_issue = (issue_cnt == '1);
    issue_next = issue_cnt + 1'b1;
  end

  // Miss/refill FSM with registered memory request outputs.
  // Address of word k is the block base with k in the offset field, which
  // equals base + 2*k without a 16-bit adder.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IC_IDLE;
      fill_tag     <= '0;
      fill_index   <= '0;
      issue_cnt    <= '0;
      ret_cnt      <= '0;
      fill_flushed <= 1'b0;
      mem_req      <= 1'b0;
      mem_addr     <= '0;
    end else begin
      if (ret_active) ret_cnt <= ret_cnt + 1'b1;
      if (flush) fill_flushed <= 1'b1;
      unique case (state)
        IC_IDLE: begin
          if (miss) begin
            fill_tag     <= req_tag;
            fill_index   <= req_index;
            issue_cnt    <= '0;
            ret_cnt      <= '0;
            fill_flushed <= 1'b0;
            mem_req      <= 1'b1;
            mem_addr     <= {req_tag, req_index, {(OFFSET_BITS+1){1'b0}}};
            state        <= IC_FILL;
          end
        end
        IC_FILL: begin
          issue_cnt <= issue_next;
          if (last_issue) begin
            mem_req  <= 1'b0;
            mem_addr <= '0;
            state    <= last_ret ? IC_IDLE : IC_WAIT;
          end else begin
            mem_addr <= {fill_tag, fill_index, issue_next, 1'b0};
          end
        end
        IC_WAIT: begin
          if (last_ret) state <= IC_IDLE;
        end
        default: state <= IC_IDLE;
      endcase
    end
  end

`ifdef ICACHE_STATS_EN
  // Saturating hit/miss statistics; unaffected by flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (hit && (hit_cnt != '1)) hit_cnt <= hit_cnt + 1'b1;
      if (miss && (miss_cnt != '1)) miss_cnt <= miss_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// Self-checking bench for icache_ctrl with a fixed-latency (L=4) memory model.
module tb_icache_ctrl;

  localparam int L = 4;

  logic        clk;
  logic        rst_n;
  logic        cpu_req;
  logic [15:0] cpu_addr;
  logic        flush;
  logic [15:0] cpu_instr;
  logic        cpu_stall;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [15:0] mem_rdata;
  logic        mem_rvalid;
`ifdef ICACHE_STATS_EN
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;
`endif

  int tests = 0;
  int fails = 0;

  logic [15:0] exp_q[$];
  logic [15:0] req_log[$];

  bit          s_v [L];
  logic [15:0] s_a [L];

  icache_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_req    (cpu_req),
    .cpu_addr   (cpu_addr),
    .flush      (flush),
    .cpu_instr  (cpu_instr),
    .cpu_stall  (cpu_stall),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid)
`ifdef ICACHE_STATS_EN
    ,
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return (a ^ 16'h3C5A) + {a[7:0], a[15:8]};
  endfunction

  // Memory model: requests return in order exactly L cycles later.
  always @(posedge clk) begin
    s_v[0] <= mem_req;
    s_a[0] <= mem_addr;
    for (int i = 1; i < L; i++) begin
      s_v[i] <= s_v[i-1];
      s_a[i] <= s_a[i-1];
    end
    if (mem_req) req_log.push_back(mem_addr);
  end

  assign mem_rvalid = s_v[L-1];
  assign mem_rdata  = s_v[L-1] ? mem_word(s_a[L-1]) : 16'hDEAD;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cpu_req = 1'b0;
      flush   = 1'b0;
    end
  endtask

  task automatic flush_pulse();
    @(negedge clk);
    cpu_req = 1'b0;
    flush   = 1'b1;
    @(negedge clk);
    flush   = 1'b0;
  endtask

  // Hold a fetch until the DUT delivers; optionally pulse flush or redirect
  // the address at a given cycle of the request (-1 = never).
  task automatic fetch(input string name, input logic [15:0] addr, input int exp_stall,
                       input int flush_at, input int redir_at, input logic [15:0] redir_addr);
    logic [15:0] a;
    logic [15:0] fin;
    logic [15:0] e;
    int stalls;
    int bad0;
    bit done;
    a      = addr;
    fin    = (redir_at >= 0) ? redir_addr : addr;
    stalls = 0;
    bad0   = 0;
    done   = 1'b0;
    exp_q.push_back(mem_word({fin[15:1], 1'b0}));
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (c == redir_at) a = redir_addr;
      cpu_req  = 1'b1;
      cpu_addr = a;
      flush    = (c == flush_at);
      #1;
      if (cpu_stall) begin
        stalls++;
        if (cpu_instr !== 16'h0000) bad0++;
      end else begin
        done = 1'b1;
        if (exp_q.size() == 0) begin
          chk({name, "_queue"}, 0, 1);
        end else begin
          e = exp_q.pop_front();
          chk({name, "_instr"}, cpu_instr, e);
        end
      end
    end
    flush = 1'b0;
    if (!done) begin
      chk({name, "_timeout"}, 0, 1);
      exp_q.delete();
    end
    chk({name, "_stall_cycles"}, stalls, exp_stall);
    chk({name, "_stalled_instr_zero"}, bad0, 0);
  endtask

  typedef struct {
    logic [15:0] addr;
    int          stall;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int bad;
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int bad;
    vecs[0] = '{16'h0002, 0};
    vecs[1] = '{16'h0004, 0};
    vecs[2] = '{16'h0006, 0};
    vecs[3] = '{16'h0007, 0};
    vecs[4] = '{16'h000C, 0};
    vecs[5] = '{16'h000E, 0};
    vecs[6] = '{16'h0020, 13};
    vecs[7] = '{16'h0022, 0};

    rst_n    = 1'b0;
    cpu_req  = 1'b0;
    cpu_addr = 16'h0000;
    flush    = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall_noreq", cpu_stall, 0);
    chk("rst_instr", cpu_instr, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    cpu_req = 1'b1;
    #1;
    chk("rst_stall_req", cpu_stall, 1);
    chk("rst_instr_req", cpu_instr, 0);
`ifdef ICACHE_STATS_EN
    chk("rst_hit_cnt", hit_cnt, 0);
    chk("rst_miss_cnt", miss_cnt, 0);
`endif
    @(negedge clk);
    cpu_req = 1'b0;
    rst_n   = 1'b1;
    @(negedge clk);

    // Cold miss at 0x0000
    req_log.delete();
    fetch("cold", 16'h0000, 13, -1, -1, 16'h0000);
    chk("cold_req_count", req_log.size(), 8);
    for (int k = 0; k < 8; k++)
      if (k < req_log.size()) chk($sformatf("cold_req_addr%0d", k), req_log[k], 2 * k);

    // Table: hits in block 0, a miss in a new block, then a hit there
    for (int i = 0; i < 8; i++) begin
      req_log.delete();
      fetch($sformatf("vec%0d", i), vecs[i].addr, vecs[i].stall, -1, -1, 16'h0000);
      chk($sformatf("vec%0d_mem_reqs", i), req_log.size(), (vecs[i].stall == 0) ? 0 : 8);
    end

    // Conflict eviction on index 0
    fetch("conflict_0400", 16'h0400, 13, -1, -1, 16'h0000);
    fetch("conflict_0000", 16'h0000, 13, -1, -1, 16'h0000);

    // Redirect during FILL: 0x0010 completes, 0x0100 then misses
    req_log.delete();
    fetch("redirect", 16'h0010, 26, -1, 2, 16'h0100);
    chk("redirect_req_count", req_log.size(), 16);
    if (req_log.size() > 8) chk("redirect_first_base", req_log[0], 16'h0010);
    if (req_log.size() > 8) chk("redirect_second_base", req_log[8], 16'h0100);
    fetch("redirect_hit_0010", 16'h0010, 0, -1, -1, 16'h0000);
    fetch("redirect_hit_0100", 16'h0100, 0, -1, -1, 16'h0000);

    // Flush after a fill
    fetch("preflush_hit", 16'h0000, 0, -1, -1, 16'h0000);
    flush_pulse();
    fetch("postflush_0000", 16'h0000, 13, -1, -1, 16'h0000);
    fetch("postflush_0010", 16'h0010, 13, -1, -1, 16'h0000);

    // Flush during WAIT, and flush on the completing cycle
    fetch("flush_wait", 16'h0030, 26, 10, -1, 16'h0000);
    fetch("flush_wait_hit", 16'h0030, 0, -1, -1, 16'h0000);
    fetch("flush_last", 16'h0040, 26, 12, -1, 16'h0000);
    fetch("flush_last_hit", 16'h0040, 0, -1, -1, 16'h0000);

    // Reset in FILL cycle 3
    flush_pulse();
    @(negedge clk);
    cpu_req  = 1'b1;
    cpu_addr = 16'h0000;
    #1;
    chk("rstfill_miss_stall", cpu_stall, 1);
    @(negedge clk);
    #1;
    chk("rstfill_fill1_req", mem_req, 1);
    repeat (2) @(negedge clk);
    #1;
    chk("rstfill_fill3_req", mem_req, 1);
    rst_n = 1'b0;
    #1;
    chk("rstfill_req_drop", mem_req, 0);
    chk("rstfill_addr_zero", mem_addr, 0);
    chk("rstfill_stall", cpu_stall, 1);
    chk("rstfill_instr", cpu_instr, 0);
    @(negedge clk);
    rst_n   = 1'b1;
    cpu_req = 1'b0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      if (cpu_stall || mem_req) bad++;
    end
    chk("stale_rvalid_ignored", bad, 0);
`ifdef ICACHE_STATS_EN
    chk("rstfill_hit_cnt", hit_cnt, 0);
    chk("rstfill_miss_cnt", miss_cnt, 0);
`endif
    req_log.delete();
    fetch("post_reset_0000", 16'h0000, 13, -1, -1, 16'h0000);
    chk("post_reset_req_count", req_log.size(), 8);
    idle(1);
    #1;
`ifdef ICACHE_STATS_EN
    chk("stats_hit_cnt", hit_cnt, 1);
    chk("stats_miss_cnt", miss_cnt, 1);
`endif
    chk("idle_no_stall", cpu_stall, 0);
    chk("idle_instr_zero", cpu_instr, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/icache_ctrl.md
Name: icache_ctrl

Overview:
- Direct-mapped instruction cache with a miss/refill FSM, sitting between the fetch stage (PC / IF-ID) and a multi-cycle main memory. It replaces the single-cycle instruction memory.
- Hits return the instruction combinationally in the same cycle.
- Misses assert a stall and refill the whole block word-by-word from memory, then replay the lookup.

Parameters:
- INDEX_BITS, 6, set-index width; number of sets = 2**INDEX_BITS.
- OFFSET_BITS, 3, word-offset width; words per block = 2**OFFSET_BITS.
- Tag width is derived, not a parameter: 15 - INDEX_BITS - OFFSET_BITS.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock, reset asynchronous active-low.
- cpu_req  in  1  fetch request valid.
- cpu_addr  in  16  byte address of the instruction; bit 0 is ignored.
- flush  in  1  single-cycle pulse; invalidates all lines.
- cpu_instr  out  16  instruction; valid when cpu_req=1 and cpu_stall=0.
- cpu_stall  out  1  freeze PC and IF-ID.
- mem_req  out  1  word read request to main memory.
- mem_addr  out  16  byte address of the requested word.
- mem_rdata  in  16  returned word.
- mem_rvalid  in  1  mem_rdata valid.

Behaviour:
- Address split:
  - tag = addr[15:OFFSET_BITS+INDEX_BITS+1]
  - index = addr[OFFSET_BITS+INDEX_BITS:OFFSET_BITS+1]
  - word = addr[OFFSET_BITS:1]
- Storage:
  - data array of flops, read asynchronously.
  - tag array and valid bits.
  - only the valid bits are reset.
- Memory contract:
  - memory accepts one mem_req per cycle.
  - it returns mem_rvalid in request order, a fixed latency L≥1 later.
  - the cache counts rvalids and does not depend on L.
- FSM states: IDLE, FILL, WAIT.
- IDLE:
  - hit = cpu_req & valid[index] & tag match. On a hit, cpu_instr = data[index][word] and cpu_stall = 0.
  - miss = cpu_req & !hit. On a miss, cpu_stall = 1 in the same cycle. The block base {tag,index,0} is latched into fill_addr, both counters clear, and the FSM goes to FILL.
  - cpu_req = 0: cpu_stall = 0, cpu_instr = 16'h0000.
- FILL:
  - mem_req = 1, mem_addr = fill_addr + 2*issue_cnt.
  - issue_cnt increments each cycle.
  - after issuing the last word, go to WAIT. If the last rvalid arrives in that same cycle (L=1), go straight to IDLE.
  - mem_req and mem_addr are registered.
- Data return (FILL and WAIT):
  - each mem_rvalid writes mem_rdata to data[fill_index][ret_cnt], then ret_cnt increments.
  - on the final word: write the tag, set valid (unless a flush occurred during the fill), and go to IDLE.
  - the next cycle re-looks-up and hits.
- Stall span: cpu_stall is 1 throughout FILL and WAIT, and cpu_instr = 16'h0000 whenever stalled. Cold-miss stall length is exactly 2**OFFSET_BITS + L + 1 cycles.
- cpu_addr changing mid-fill (branch redirect):
  - the fill completes for the latched block.
  - the lookup then uses the new cpu_addr.
  - this may miss again.
- flush:
  - clears all valid bits at the next edge, in any state.
  - if a fill is in progress, it completes and writes data, but the line's valid bit stays 0.
  - flush and a refill completing in the same cycle: flush wins.
- mem_rvalid while in IDLE is ignored.
- rst_n low (including mid-fill):
  - state = IDLE, valid all 0, counters 0.
  - mem_req = 0, mem_addr = 0.
  - outputs are then cpu_instr = 0, and cpu_stall = cpu_req (any request misses).
- Reset values: mem_req 0, mem_addr 16'h0000, cpu_stall combinational per the above.

Optional Feature:
- Macro: ICACHE_STATS_EN.
- Defined:
  - adds outputs hit_cnt[15:0] and miss_cnt[15:0].
  - hit_cnt increments on each IDLE cycle with a hit.
  - miss_cnt increments once per miss detection, not per stall cycle.
  - both saturate at 16'hFFFF, reset to 0 on rst_n, and are unaffected by flush.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package (cache_pkg):
  - state encoding IC_IDLE/IC_FILL/IC_WAIT.
  - default INDEX_BITS and OFFSET_BITS.
  - the stall-instruction constant 16'h0000.
- One natural sub-module, icache_array:
  - tag, valid and data storage.
  - async read port.
  - one word-write port, a tag/valid write port, and a flush-all input.
- The FSM and counters stay in icache_ctrl.

Test Plan (all cases with a bench memory model at L=4):
- Cold miss: cpu_addr=0x0000 after reset.
  - mem_req for 8 consecutive cycles, mem_addr 0x0000..0x000E.
  - cpu_stall high for exactly 13 cycles, then cpu_instr = the word at 0x0000.
- Hits in the same block: addresses 0x0002..0x000E after the fill.
  - no mem_req.
  - cpu_stall = 0, correct words in the same cycle.
- Conflict eviction: fetch 0x0400 (same index 0, different tag).
  - miss and refill.
  - a subsequent 0x0000 misses again.
- Redirect mid-fill: change cpu_addr from 0x0010 to 0x0100 during FILL.
  - the block at 0x0010 completes.
  - 0x0100 then misses.
  - a later 0x0010 hits.
- Flush:
  - flush pulse after a fill: the next fetch of 0x0000 misses.
  - flush during WAIT: the fill completes, but the line is still invalid afterwards.
- Reset mid-fill: rst_n low in FILL cycle 3.
  - mem_req drops immediately.
  - after release, 0x0000 misses.
  - stale rvalids in IDLE are ignored, and hit_cnt/miss_cnt return to 0 (under ICACHE_STATS_EN).
